// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns single-cycle CPU load/store strobes into a held
// req/ack bus transaction and stalls the CPU until it completes. Optional macro: DMEM_TIMEOUT_EN.
module dmem_bus_ctrl #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memrd,
    input  logic              cpu_memwr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_halt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                strobe;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                bus_err_q, bus_err_d;
`else
    // Timeout parameters only matter when the timeout logic is built in.
    logic [DATA_W:0]     unused_cfg;
    assign unused_cfg = {ERR_RDATA, TIMEOUT_CYCLES[0]};
`endif

    // A simultaneous read+write strobe is treated as a write.
    assign strobe = cpu_memrd | cpu_memwr;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_halt    = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                cpu_halt = strobe;
                if (strobe) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_memwr;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
`ifdef DMEM_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                cpu_halt = 1'b1;
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                // An ack on the expiry cycle takes priority over the abort.
                else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) begin
                        cpu_rdata_d = ERR_RDATA;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                // CPU retires here; whatever strobes it still shows are the old access.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
`ifdef DMEM_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed testbench for dmem_bus_ctrl: reset, read/write latency, back-to-back,
// reset abort, dual strobe, and timeout behaviour (DMEM_TIMEOUT_EN builds).
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memrd;
    logic        cpu_memwr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_halt;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    dmem_bus_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_memrd(cpu_memrd),
        .cpu_memwr(cpu_memwr),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_halt(cpu_halt),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Count bus request assertions, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_memrd = 1'b0;
        cpu_memwr = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, cpu_halt, bus_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, mem_we, cpu_halt, bus_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, cpu_rdata});
        end
        $display("test_reset done");
    endtask

    task automatic test_read_ack3();
        tick();
        cpu_memrd = 1'b1; cpu_addr = 32'h40;
        #1;
        checks++;
        if ({cpu_halt, mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL rd_idle_halt got=%b exp=10", {cpu_halt, mem_req});
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end
            #1;
            checks++;
            if ({cpu_halt, mem_req, mem_we, mem_addr} !== {3'b110, 32'h40}) begin
                errors++;
                $display("FAIL rd_busy%0d got=%b_%h exp=110_00000040", k,
                         {cpu_halt, mem_req, mem_we}, mem_addr);
            end
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++;
        if ({cpu_halt, mem_req, cpu_rdata} !== {2'b00, 32'h1234_5678}) begin
            errors++;
            $display("FAIL rd_done got=%b_%h exp=00_12345678", {cpu_halt, mem_req}, cpu_rdata);
        end
        cpu_memrd = 1'b0;
        tick();
        checks++;
        if ({cpu_halt, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL rd_after got=%b exp=00", {cpu_halt, mem_req});
        end
        $display("test_read_ack3 done rdata=%h", cpu_rdata);
    endtask

    task automatic test_write_fast();
        cpu_memwr = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'hCAFE;
        #1;
        checks++;
        if (cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL wr_idle_halt got=%b exp=1", cpu_halt);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        #1;
        checks++;
        if ({cpu_halt, mem_req, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h8, 32'hCAFE}) begin
            errors++;
            $display("FAIL wr_busy got=%b_%h_%h exp=111_00000008_0000cafe",
                     {cpu_halt, mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({cpu_halt, mem_req, cpu_rdata} !== {2'b00, 32'h1234_5678}) begin
            errors++;
            $display("FAIL wr_done got=%b_%h exp=00_12345678", {cpu_halt, mem_req}, cpu_rdata);
        end
        cpu_memwr = 1'b0;
        tick();
        $display("test_write_fast done");
    endtask

    task automatic test_back_to_back();
        int rises0;
        rises0 = req_rises;
        cpu_memrd = 1'b1; cpu_addr = 32'h20;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({cpu_halt, mem_req, cpu_rdata} !== {2'b00, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL b2b_ld_done got=%b_%h exp=00_a5a5a5a5", {cpu_halt, mem_req}, cpu_rdata);
        end
        tick();
        cpu_memrd = 1'b0; cpu_memwr = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'h77;
        #1;
        checks++;
        if ({cpu_halt, mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_st_idle got=%b exp=10", {cpu_halt, mem_req});
        end
        tick();
        mem_ack = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h24, 32'h77}) begin
            errors++;
            $display("FAIL b2b_st_busy got=%b_%h_%h exp=11_00000024_00000077",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
        tick();
        cpu_memwr = 1'b0;
        tick();
        tick();
        checks++;
        if (req_rises - rises0 !== 2) begin
            errors++;
            $display("FAIL b2b_req_count got=%0d exp=2", req_rises - rises0);
        end
        $display("test_back_to_back done requests=%0d", req_rises - rises0);
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({cpu_halt, mem_req, cpu_rdata} !== {2'b00, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL idle_ack got=%b_%h exp=00_a5a5a5a5", {cpu_halt, mem_req}, cpu_rdata);
        end
        $display("test_spurious_ack done");
    endtask

    task automatic test_reset_mid();
        cpu_memrd = 1'b1; cpu_addr = 32'h50;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy got=%b exp=1", mem_req);
        end
        reset = 1'b1; cpu_memrd = 1'b0;
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({mem_req, cpu_halt, cpu_rdata, mem_addr} !== 66'h0) begin
            errors++;
            $display("FAIL rst_mid_clear got=%b_%h_%h exp=00_0_0", {mem_req, cpu_halt}, cpu_rdata, mem_addr);
        end
        tick();
        mem_ack = 1'b0;
        cpu_memrd = 1'b1; cpu_addr = 32'h54;
        #1;
        checks++;
        if ({cpu_halt, mem_req, cpu_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_idle got=%b_%h exp=10_00000000", {cpu_halt, mem_req}, cpu_rdata);
        end
        cpu_memrd = 1'b0;
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_both_strobes();
        cpu_memrd = 1'b1; cpu_memwr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h99;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h10, 32'h99}) begin
            errors++;
            $display("FAIL both_busy got=%b_%h_%h exp=11_00000010_00000099",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({cpu_halt, mem_req, cpu_rdata} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL both_done got=%b_%h exp=00_00000000", {cpu_halt, mem_req}, cpu_rdata);
        end
        cpu_memrd = 1'b0; cpu_memwr = 1'b0;
        tick();
        $display("test_both_strobes done");
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        cpu_memrd = 1'b1; cpu_addr = 32'h60;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({mem_req, cpu_halt, bus_err} !== 3'b110) begin
                errors++;
                $display("FAIL tmo_busy%0d got=%b exp=110", k, {mem_req, cpu_halt, bus_err});
            end
        end
        tick();
        checks++;
        if ({mem_req, cpu_halt, bus_err, cpu_rdata} !== {3'b001, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL tmo_done got=%b_%h exp=001_deadbeef", {mem_req, cpu_halt, bus_err}, cpu_rdata);
        end
        cpu_memrd = 1'b0;
        tick();
        cpu_memwr = 1'b1; cpu_addr = 32'h64; cpu_wdata = 32'h1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; cpu_memwr = 1'b0;
        tick();
        checks++;
        if ({mem_req, bus_err} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_sticky got=%b exp=01", {mem_req, bus_err});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_reset got=%b exp=0", bus_err);
        end
        // Ack on the expiry cycle completes normally.
        cpu_memrd = 1'b1; cpu_addr = 32'h68;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'h3C3C_3C3C;
            end
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, bus_err, cpu_rdata} !== {2'b00, 32'h3C3C_3C3C}) begin
            errors++;
            $display("FAIL tmo_ack_wins got=%b_%h exp=00_3c3c3c3c", {mem_req, bus_err}, cpu_rdata);
        end
        cpu_memrd = 1'b0;
        tick();
        $display("test_timeout done");
    endtask
`else
    task automatic test_no_timeout();
        cpu_memrd = 1'b1; cpu_addr = 32'h60;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({mem_req, cpu_halt, bus_err} !== 3'b110) begin
                errors++;
                $display("FAIL notmo_busy%0d got=%b exp=110", k, {mem_req, cpu_halt, bus_err});
            end
        end
        mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, bus_err, cpu_rdata} !== {2'b00, 32'h0F0F_0F0F}) begin
            errors++;
            $display("FAIL notmo_done got=%b_%h exp=00_0f0f0f0f", {mem_req, bus_err}, cpu_rdata);
        end
        cpu_memrd = 1'b0;
        tick();
        $display("test_no_timeout done");
    endtask
`endif

    initial begin
        test_reset();
        test_read_ack3();
        test_write_fast();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid();
        test_both_strobes();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
